// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and PC increment.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter used for fetch stall statistics.
module fetch_perf_cnt
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  inc,
    output word_t count
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + word_t'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, requests words from the icache,
// holds each fetched word for a valid/ready handshake, follows redirects
// and stops for good on halt.
// Optional feature macro: FETCH_PERF_EN adds the fetch_stall_cnt output.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    output logic  iREN,
    output word_t iaddr,
    input  logic  ihit,
    input  word_t iload,
    output word_t imemload,
    output logic  instr_valid,
    input  logic  instr_ready,
    output word_t instr_pc,
    output word_t npc,
    input  logic  pc_load,
    input  word_t pc_target,
    input  logic  halt
`ifdef FETCH_PERF_EN
    ,
    output word_t fetch_stall_cnt
`endif
);

    localparam word_t ALIGN_MASK = ~word_t'(3);
    localparam word_t PC_RESET   = PC_INIT & ALIGN_MASK;

    fetch_state_t state, state_nxt;
    word_t        pc, pc_nxt;
    word_t        ir, ir_nxt;

    // State, PC and instruction registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            pc    <= PC_RESET;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next state: halt beats redirect, redirect beats hit/consume.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        if (halt) begin
            state_nxt = HALTED;
        end else begin
            case (state)
                FETCH: begin
                    if (pc_load) begin
                        pc_nxt    = pc_target & ALIGN_MASK;
                        state_nxt = FETCH;
                    end else if (ihit) begin
                        ir_nxt    = iload;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (pc_load) begin
                        pc_nxt    = pc_target & ALIGN_MASK;
                        state_nxt = FETCH;
                    end else if (instr_ready) begin
                        pc_nxt    = pc + PC_STEP;
                        state_nxt = FETCH;
                    end
                end
                HALTED: begin
                    state_nxt = HALTED;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; no request while reset is held.
    assign iREN        = (state == FETCH) && !RST;
    assign iaddr       = pc;
    assign instr_valid = (state == HOLD);
    assign imemload    = ir;
    assign instr_pc    = pc;
    assign npc         = pc + PC_STEP;

`ifdef FETCH_PERF_EN
    // Cycles spent requesting without a hit; HALTED never counts.
    fetch_perf_cnt u_perf_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   ((state == FETCH) && !ihit),
        .count (fetch_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;

    logic  CLK = 1'b0;
    logic  RST;
    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;
    word_t imemload;
    logic  instr_valid;
    logic  instr_ready;
    word_t instr_pc;
    word_t npc;
    logic  pc_load;
    word_t pc_target;
    logic  halt;
`ifdef FETCH_PERF_EN
    word_t fetch_stall_cnt;
`endif

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .ihit        (ihit),
        .iload       (iload),
        .imemload    (imemload),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_pc    (instr_pc),
        .npc         (npc),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .halt        (halt)
`ifdef FETCH_PERF_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    typedef struct packed {
        word_t pc;
        word_t word;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    word_t       exp_pc;
    int unsigned exp_stall;
    bit          dummy_halted;

    task automatic check(input string name, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_stall(input string name);
`ifdef FETCH_PERF_EN
        check(name, fetch_stall_cnt, word_t'(exp_stall));
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // Monitor: every cycle a word is offered, it must match the oldest fetched word.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (!RST && instr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: instr_pc %h offered, none expected", instr_pc);
                end else begin
                    check("imemload", imemload, exp_q[0].word);
                    check("instr_pc", instr_pc, exp_q[0].pc);
                    check("npc", npc, exp_q[0].pc + 32'd4);
                    if (!halt && (instr_ready || pc_load)) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive_quiet();
        ihit        = 1'b0;
        iload       = '0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        pc_target   = '0;
        halt        = 1'b0;
    endtask

    // Reset with request outstanding; leaves time at negedge+1 after release.
    task automatic do_reset();
        RST = 1'b1;
        drive_quiet();
        #1;
        check("rst_iREN", word_t'(iREN), word_t'(0));
        check("rst_valid", word_t'(instr_valid), word_t'(0));
        check("rst_iaddr", iaddr, PC_INIT);
        check("rst_instr_pc", instr_pc, PC_INIT);
        check("rst_imemload", imemload, word_t'(0));
        @(negedge CLK);
        check("rst_iREN_hold", word_t'(iREN), word_t'(0));
        RST       = 1'b0;
        exp_pc    = PC_INIT;
        exp_stall = 0;
        exp_q.delete();
        #1;
    endtask

    // One fetch transaction: n_miss miss cycles then a hit, then n_wait idle HOLD cycles
    // then consume. Optional redirect in fetch (redir_f) or hold (redir_h), optional halt.
    task automatic fetch_txn(input int n_miss, input word_t word, input int redir_f,
                             input int n_wait, input int redir_h, input bit ready_at_redir,
                             input word_t tgt, input bit halt_h, output bit halted);
        halted = 1'b0;
        for (int i = 0; i <= n_miss; i++) begin
            check("fetch_iREN", word_t'(iREN), word_t'(1));
            check("fetch_iaddr", iaddr, exp_pc);
            check("fetch_no_valid", word_t'(instr_valid), word_t'(0));
            ihit        = (i == n_miss);
            iload       = (i == n_miss) ? word : word_t'($urandom);
            instr_ready = 1'($urandom);
            pc_load     = (i == redir_f);
            pc_target   = tgt;
            halt        = 1'b0;
            if (!ihit) exp_stall++;
            if (pc_load) begin
                exp_pc = tgt & ~word_t'(3);
                @(negedge CLK);
                return;
            end
            if (ihit) exp_q.push_back('{pc: exp_pc, word: word});
            @(negedge CLK);
        end
        for (int j = 0; j <= n_wait; j++) begin
            check("hold_iREN", word_t'(iREN), word_t'(0));
            check("hold_valid", word_t'(instr_valid), word_t'(1));
            ihit        = 1'($urandom);
            iload       = word_t'($urandom);
            pc_load     = (j == redir_h);
            halt        = pc_load && halt_h;
            instr_ready = (j == n_wait) || (pc_load && ready_at_redir);
            pc_target   = tgt;
            if (halt) begin
                halted = 1'b1;
                @(negedge CLK);
                return;
            end
            if (pc_load) begin
                exp_pc = tgt & ~word_t'(3);
                @(negedge CLK);
                return;
            end
            if (instr_ready) exp_pc = exp_pc + 32'd4;
            @(negedge CLK);
        end
    endtask

    // After halt: nothing requested or offered, PC frozen, whatever the inputs do.
    task automatic halted_window(input int n);
        for (int k = 0; k < n; k++) begin
            check("halt_iREN", word_t'(iREN), word_t'(0));
            check("halt_valid", word_t'(instr_valid), word_t'(0));
            check("halt_iaddr", iaddr, exp_pc);
            ihit        = 1'($urandom);
            iload       = word_t'($urandom);
            instr_ready = 1'($urandom);
            pc_load     = 1'($urandom);
            pc_target   = word_t'($urandom);
            halt        = 1'($urandom);
            @(negedge CLK);
        end
        drive_quiet();
        check_stall("halt_stall_frozen");
    endtask

    initial begin
        RST = 1'b1;
        drive_quiet();
        exp_pc    = PC_INIT;
        exp_stall = 0;
        @(negedge CLK);
        do_reset();

        // First word: hit on the second request cycle.
        fetch_txn(1, 32'h2001_0005, -1, 0, -1, 1'b0, '0, 1'b0, dummy_halted);

        // Back-to-back stream from reset.
        do_reset();
        for (int n = 0; n < 3; n++)
            fetch_txn(0, word_t'($urandom), -1, 0, -1, 1'b0, '0, 1'b0, dummy_halted);

        // Long stall in HOLD, then consume.
        fetch_txn(0, word_t'($urandom), -1, 5, -1, 1'b0, '0, 1'b0, dummy_halted);

        // Redirect coinciding with a hit: word dropped, target aligned.
        fetch_txn(0, word_t'($urandom), 0, 0, -1, 1'b0, 32'h0000_0103, 1'b0, dummy_halted);
        fetch_txn(0, word_t'($urandom), -1, 0, -1, 1'b0, '0, 1'b0, dummy_halted);

        // Redirect while consuming in HOLD: target wins over PC+4.
        fetch_txn(0, word_t'($urandom), -1, 2, 1, 1'b1, 32'h0000_2222, 1'b0, dummy_halted);

        // Halt together with redirect in HOLD.
        fetch_txn(0, word_t'($urandom), -1, 3, 1, 1'b0, 32'h0000_0040, 1'b1, dummy_halted);
        check("halt_taken", word_t'(dummy_halted), word_t'(1));
        halted_window(20);
        do_reset();

        // Miss counting and PC wrap at the top of the address space.
        fetch_txn(3, word_t'($urandom), -1, 0, -1, 1'b0, '0, 1'b0, dummy_halted);
        check_stall("stall_after_3_miss");
        fetch_txn(0, word_t'($urandom), 0, 0, -1, 1'b0, 32'hFFFF_FFFC, 1'b0, dummy_halted);
        fetch_txn(1, word_t'($urandom), -1, 1, -1, 1'b0, '0, 1'b0, dummy_halted);
        check("wrap_iaddr", iaddr, word_t'(0));

        // Random traffic with redirects anywhere.
        for (int t = 0; t < 150; t++) begin
            int    nm, rf, nw, rh;
            word_t tg;
            nm = int'($urandom_range(0, 3));
            nw = int'($urandom_range(0, 3));
            rf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (rf > nm) rf = nm;
            rh = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (rh > nw) rh = nw;
            tg = word_t'($urandom);
            fetch_txn(nm, word_t'($urandom), rf, nw, rh, 1'($urandom), tg, 1'b0, dummy_halted);
        end
        check_stall("stall_random");

        // Halt while a request is outstanding.
        ihit        = 1'($urandom);
        iload       = word_t'($urandom);
        instr_ready = 1'b0;
        pc_load     = 1'($urandom);
        pc_target   = word_t'($urandom);
        halt        = 1'b1;
        if (!ihit) exp_stall++;
        @(negedge CLK);
        halted_window(10);

        check("queue_drained", word_t'(exp_q.size()), word_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
